song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer.sv | 92 +++++++++
 tb/tb_song_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: steps through per-song {note, duration} ROM entries and hands each note to a player
// Ports: clk, reset (sync, active-high); play level run/pause; song select latched on leaving IDLE;
//        note_done/skip pulses advance the current note; repeat_en restarts a finished song;
//        rom_addr = {latched song, index}, rom_dout valid one cycle later;
//        note/duration registered note output, new_note pulse per note, song_done pulse, busy.
module song_sequencer #(
   parameter int SONG_BITS = 2,
   parameter int ADDR_BITS = 5,
   parameter int NOTE_BITS = 6,
   parameter int DUR_BITS  = 6
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           play,
   input  logic [SONG_BITS-1:0]           song,
   input  logic                           note_done,
   input  logic                           skip,
   input  logic                           repeat_en,
   output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
   input  logic [NOTE_BITS+DUR_BITS-1:0]  rom_dout,
   output logic [NOTE_BITS-1:0]           note,
   output logic [DUR_BITS-1:0]            duration,
   output logic                           new_note,
   output logic                           song_done,
   output logic                           busy
);
   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_DONE, END_S} state_t;
   localparam logic [ADDR_BITS-1:0] LAST = '1;
   state_t               state;
   logic [SONG_BITS-1:0] song_l;
   logic [ADDR_BITS-1:0] idx;
   logic [NOTE_BITS-1:0] note_f;
   logic [DUR_BITS-1:0]  dur_f;
   assign rom_addr = {song_l, idx};
   assign dur_f    = rom_dout[DUR_BITS-1:0];
   assign note_f   = rom_dout[NOTE_BITS+DUR_BITS-1:DUR_BITS];
   // busy tracks the next state so it is registered alongside it
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         song_l    <= '0;
         idx       <= '0;
         note      <= '0;
         duration  <= '0;
         new_note  <= 1'b0;
         song_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         new_note  <= 1'b0;
         song_done <= 1'b0;
         case (state)
            IDLE: if (play) begin
               song_l <= song;
               idx    <= '0;
               state  <= FETCH;
               busy   <= 1'b1;
            end
            FETCH: state <= ISSUE;
            // a zero duration marks the end of the song
            ISSUE: if (dur_f == '0) begin
               state     <= END_S;
               song_done <= 1'b1;
            end else begin
               note     <= note_f;
               duration <= dur_f;
               new_note <= 1'b1;
               state    <= WAIT_DONE;
            end
            WAIT_DONE: if (play && (note_done || skip)) begin
               if (idx != LAST) begin
                  idx   <= idx + 1'b1;
                  state <= FETCH;
               end else begin
                  state     <= END_S;
                  song_done <= 1'b1;
               end
            end
            END_S: if (repeat_en && play) begin
               idx   <= '0;
               state <= FETCH;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed table plus hand sequences for song_sequencer
module tb_song_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1, play = 1'b0, note_done = 1'b0, skip = 1'b0, repeat_en = 1'b0;
   logic [1:0]  song = 2'd0;
   logic [6:0]  rom_addr;
   logic [11:0] rom_dout = '0;
   logic [5:0]  note, duration;
   logic        new_note, song_done, busy;
   logic [11:0] rom [128];
   int tests = 0, fails = 0;

   song_sequencer dut (
      .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done), .skip(skip),
      .repeat_en(repeat_en), .rom_addr(rom_addr), .rom_dout(rom_dout), .note(note),
      .duration(duration), .new_note(new_note), .song_done(song_done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_dout <= rom[rom_addr];

   typedef struct {
      logic rst, pl; logic [1:0] sg; logic nd, sk, rp;
      logic [6:0] addr; logic [5:0] nt, dr; logic nn, sd, bz;
   } vec_t;
   vec_t v [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      int nn_cnt, bad_range;
      logic got;
      for (int i = 0; i < 128; i++) rom[i] = '0;
      rom[0]  = {6'd1, 6'd1};
      rom[32] = {6'd5, 6'd4};
      rom[33] = {6'd7, 6'd3};
      rom[64] = {6'd9, 6'd2};
      for (int i = 0; i < 32; i++) rom[96+i] = {6'(i+1), 6'(i+1)};
      //        rst pl sg nd sk rp  addr nt dr nn sd bz
      v[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
      v[1]  = '{0, 1, 1, 0, 0, 0,  32, 0, 0, 0, 0, 1};
      v[2]  = '{0, 1, 1, 1, 0, 0,  32, 0, 0, 0, 0, 1};
      v[3]  = '{0, 1, 1, 0, 1, 0,  32, 5, 4, 1, 0, 1};
      v[4]  = '{0, 1, 1, 0, 0, 0,  32, 5, 4, 0, 0, 1};
      v[5]  = '{0, 1, 1, 1, 1, 0,  33, 5, 4, 0, 0, 1};
      v[6]  = '{0, 1, 2, 0, 0, 0,  33, 5, 4, 0, 0, 1};
      v[7]  = '{0, 1, 2, 0, 0, 0,  33, 7, 3, 1, 0, 1};
      v[8]  = '{0, 0, 2, 1, 0, 0,  33, 7, 3, 0, 0, 1};
      v[9]  = '{0, 0, 2, 0, 1, 0,  33, 7, 3, 0, 0, 1};
      v[10] = '{0, 1, 2, 0, 0, 0,  33, 7, 3, 0, 0, 1};
      v[11] = '{0, 1, 2, 1, 0, 0,  34, 7, 3, 0, 0, 1};
      v[12] = '{0, 1, 2, 0, 0, 0,  34, 7, 3, 0, 0, 1};
      v[13] = '{0, 1, 2, 1, 0, 0,  34, 7, 3, 0, 1, 1};
      v[14] = '{0, 1, 2, 0, 0, 0,  34, 7, 3, 0, 0, 0};
      v[15] = '{0, 0, 2, 0, 0, 0,  34, 7, 3, 0, 0, 0};
      v[16] = '{0, 1, 2, 0, 0, 0,  64, 7, 3, 0, 0, 1};
      v[17] = '{0, 1, 2, 0, 0, 0,  64, 7, 3, 0, 0, 1};
      v[18] = '{0, 1, 2, 0, 0, 0,  64, 9, 2, 1, 0, 1};
      v[19] = '{1, 1, 2, 1, 1, 1,   0, 0, 0, 0, 0, 0};
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         {reset, play, song, note_done, skip, repeat_en} = {v[i].rst, v[i].pl, v[i].sg, v[i].nd, v[i].sk, v[i].rp};
         @(posedge clk);
         #1;
         check($sformatf("vec%0d {addr,note,dur,nn,sd,busy}", i),
               32'({rom_addr, note, duration, new_note, song_done, busy}),
               32'({v[i].addr, v[i].nt, v[i].dr, v[i].nn, v[i].sd, v[i].bz}));
      end
      // full 32-entry song 3, repeat enabled so it restarts after song_done
      {reset, play, song, note_done, skip, repeat_en} = {1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1};
      nn_cnt = 0; bad_range = 0; got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(posedge clk);
         #1;
         note_done = 1'b0;
         if (rom_addr < 7'd96) bad_range++;
         if (new_note) begin
            check("song3 note", 32'(note), 32'(nn_cnt + 1));
            nn_cnt++;
            note_done = 1'b1;
         end
         if (song_done) got = 1'b1;
      end
      check("song3 song_done seen", 32'(got), 32'd1);
      check("song3 new_note count", 32'(nn_cnt), 32'd32);
      check("song3 addr out of range", 32'(bad_range), 32'd0);
      @(posedge clk);
      #1;
      check("repeat addr", 32'(rom_addr), 32'd96);
      check("repeat busy", 32'(busy), 32'd1);
      check("repeat song_done cleared", 32'(song_done), 32'd0);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(posedge clk);
         #1;
         if (new_note) got = 1'b1;
      end
      check("repeat new_note seen", 32'(got), 32'd1);
      check("repeat first note/dur", 32'({note, duration}), 32'({6'd1, 6'd1}));
      // reset in the middle of a note
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid-note reset outputs", 32'({rom_addr, note, duration, new_note, song_done, busy}), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
